// File: rtl/control_filtro_promedio_pkg.sv
// rtl/control_filtro_promedio_pkg.sv - shared types and constants for the averaging-filter sequencer
// Purpose: FSM state encoding, error codes, counter width and a saturating increment helper.
// Ports: none (package filtro_ctrl_pkg).
// Configuration macro: CTRL_TIMEOUT_EN (consumed by control_filtro_promedio).
package filtro_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_FLT = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_LLENO   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

endpackage

// File: rtl/control_filtro_promedio_if.sv
// rtl/control_filtro_promedio_if.sv - source/filter handshake bundle for the sequencer
// Purpose: groups the upstream sample handshake and the filter control/status lines.
// Ports (signals): src_valid, src_ready, flt_reset_n, flt_enable, flt_data_valid,
//   flt_ptos_x_ciclo[15:0], flt_frames[15:0], flt_ready, flt_lleno, flt_out_valid.
// Modports: master (sequencer side), slave (source + filter side).
// Configuration macro: none.
interface filtro_if;
    logic        src_valid;
    logic        src_ready;
    logic        flt_reset_n;
    logic        flt_enable;
    logic        flt_data_valid;
    logic [15:0] flt_ptos_x_ciclo;
    logic [15:0] flt_frames;
    logic        flt_ready;
    logic        flt_lleno;
    logic        flt_out_valid;

    modport master (
        input  src_valid, flt_ready, flt_lleno, flt_out_valid,
        output src_ready, flt_reset_n, flt_enable, flt_data_valid,
               flt_ptos_x_ciclo, flt_frames
    );

    modport slave (
        output src_valid, flt_ready, flt_lleno, flt_out_valid,
        input  src_ready, flt_reset_n, flt_enable, flt_data_valid,
               flt_ptos_x_ciclo, flt_frames
    );
endinterface

// File: rtl/control_filtro_promedio_watchdog.sv
// rtl/control_filtro_promedio_watchdog.sv - loadable/clearable cycle counter with terminal flag
// Purpose: module ctrl_watchdog; counts enabled cycles and flags the LIMIT-th one.
// Ports: clock, reset (sync, active-high), clr, load, load_val[WIDTH-1:0], en, term.
// Configuration macro: instantiated only when CTRL_TIMEOUT_EN is defined.
module ctrl_watchdog #(
    parameter int WIDTH = 32,
    parameter int LIMIT = 65536
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             term
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !term)
            count <= count + WIDTH'(1);
    end

    // Asserted during the LIMIT-th consecutive enabled cycle.
    assign term = en && !load && !clr && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/control_filtro_promedio.sv
// rtl/control_filtro_promedio.sv - run sequencer for the moving-average filter
// Purpose: validates/latches the configuration, resets and clears the filter, gates
//   samples into it, counts outputs to completion and reports errors.
// Ports: clock, reset (sync, active-high), start, abort, cfg_ptos_x_ciclo[15:0],
//   cfg_frames[15:0], cfg_n_salidas[31:0], bus (filtro_if.master), busy, done,
//   error, err_code[1:0], muestras_in[31:0], salidas_out[31:0].
// Configuration macro: CTRL_TIMEOUT_EN enables the CLEAR/RUN watchdog (err_code 3).
module control_filtro_promedio
    import filtro_ctrl_pkg::*;
#(
    parameter int BUF_TAM        = 4096,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_ptos_x_ciclo,
    input  logic [15:0]      cfg_frames,
    input  logic [31:0]      cfg_n_salidas,
    filtro_if.master         bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] muestras_in,
    output logic [CNT_W-1:0] salidas_out
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state, state_nx;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nx;
    logic [31:0]      n_sal_q, n_sal_nx;
    logic [15:0]      m_q, m_nx, f_q, f_nx;
    logic [CNT_W-1:0] muestras_q, muestras_nx, salidas_q, salidas_nx, sal_inc;
    logic             error_q, error_nx;
    logic [1:0]       code_q, code_nx;
    logic             src_ready_q, flt_reset_n_q, flt_enable_q, flt_dv_q, busy_q, done_q;
    logic             fwd;
    logic [31:0]      mxn;
    logic             cfg_bad;
    logic             wd_timeout;

`ifdef CTRL_TIMEOUT_EN
    logic wd_clr, wd_evt, wd_en;

    // Only CLEAR and RUN are watched; any progress event restarts the count.
    assign wd_clr = !((state == ST_CLEAR) || (state == ST_RUN));
    assign wd_evt = ((state == ST_CLEAR) && bus.flt_ready) ||
                    ((state == ST_RUN) && bus.flt_out_valid);
    assign wd_en  = !wd_clr && !wd_evt;

    ctrl_watchdog #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clr      (wd_clr),
        .load     (wd_evt),
        .load_val ('0),
        .en       (wd_en),
        .term     (wd_timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_timeout     = 1'b0;
`endif

    assign mxn     = {16'd0, cfg_ptos_x_ciclo} * {16'd0, cfg_frames};
    assign cfg_bad = (cfg_ptos_x_ciclo == 16'd0) || (cfg_frames == 16'd0) ||
                     (mxn > 32'(BUF_TAM)) || (cfg_n_salidas == 32'd0);
    assign sal_inc = sat_inc(salidas_q, bus.flt_out_valid);

    always_comb begin
        state_nx    = state;
        rst_cnt_nx  = rst_cnt;
        n_sal_nx    = n_sal_q;
        m_nx        = m_q;
        f_nx        = f_q;
        muestras_nx = muestras_q;
        salidas_nx  = salidas_q;
        error_nx    = error_q;
        code_nx     = code_q;
        fwd         = 1'b0;

        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    m_nx     = cfg_ptos_x_ciclo;
                    f_nx     = cfg_frames;
                    n_sal_nx = cfg_n_salidas;
                    if (cfg_bad) begin
                        state_nx = ST_ERR;
                        error_nx = 1'b1;
                        code_nx  = ERR_CFG;
                    end else begin
                        state_nx    = ST_RST_FLT;
                        rst_cnt_nx  = '0;
                        muestras_nx = '0;
                        salidas_nx  = '0;
                        error_nx    = 1'b0;
                        code_nx     = ERR_NONE;
                    end
                end else if (abort && (state == ST_ERR)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RST_FLT: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (rst_cnt == RST_W'(RST_CYCLES - 1))
                    state_nx = ST_CLEAR;
                else
                    rst_cnt_nx = rst_cnt + RST_W'(1);
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (bus.flt_ready) begin
                    state_nx = ST_RUN;
                end else if (wd_timeout) begin
                    state_nx = ST_ERR;
                    error_nx = 1'b1;
                    code_nx  = ERR_TIMEOUT;
                end
            end
            ST_RUN: begin
                // Completion is checked before overflow so a simultaneous
                // final output and FIFO-full still ends cleanly.
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (sal_inc >= n_sal_q) begin
                    state_nx   = ST_DONE;
                    salidas_nx = sal_inc;
                end else if (bus.flt_lleno) begin
                    state_nx   = ST_ERR;
                    salidas_nx = sal_inc;
                    error_nx   = 1'b1;
                    code_nx    = ERR_LLENO;
                end else if (wd_timeout) begin
                    state_nx   = ST_ERR;
                    salidas_nx = sal_inc;
                    error_nx   = 1'b1;
                    code_nx    = ERR_TIMEOUT;
                end else begin
                    salidas_nx = sal_inc;
                    fwd        = bus.src_valid;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        muestras_nx = sat_inc(muestras_nx, fwd);
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            rst_cnt       <= '0;
            n_sal_q       <= '0;
            m_q           <= '0;
            f_q           <= '0;
            muestras_q    <= '0;
            salidas_q     <= '0;
            error_q       <= 1'b0;
            code_q        <= ERR_NONE;
            src_ready_q   <= 1'b0;
            flt_reset_n_q <= 1'b1;
            flt_enable_q  <= 1'b0;
            flt_dv_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nx;
            rst_cnt       <= rst_cnt_nx;
            n_sal_q       <= n_sal_nx;
            m_q           <= m_nx;
            f_q           <= f_nx;
            muestras_q    <= muestras_nx;
            salidas_q     <= salidas_nx;
            error_q       <= error_nx;
            code_q        <= code_nx;
            src_ready_q   <= (state_nx == ST_RUN);
            flt_reset_n_q <= (state_nx != ST_RST_FLT);
            flt_enable_q  <= (state_nx == ST_RUN);
            flt_dv_q      <= fwd;
            busy_q        <= (state_nx == ST_RST_FLT) || (state_nx == ST_CLEAR) ||
                             (state_nx == ST_RUN);
            done_q        <= (state_nx == ST_DONE);
        end
    end

    assign bus.src_ready        = src_ready_q;
    assign bus.flt_reset_n      = flt_reset_n_q;
    assign bus.flt_enable       = flt_enable_q;
    assign bus.flt_data_valid   = flt_dv_q;
    assign bus.flt_ptos_x_ciclo = m_q;
    assign bus.flt_frames       = f_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign err_code             = code_q;
    assign muestras_in          = muestras_q;
    assign salidas_out          = salidas_q;

endmodule

// File: tb/tb_control_filtro_promedio.sv
// tb/tb_control_filtro_promedio.sv - directed self-checking bench for control_filtro_promedio
// Purpose: drives launch, bad-config, overflow, done-vs-overflow, abort and watchdog scenarios.
// Ports: none (top-level bench). Configuration macro: CTRL_TIMEOUT_EN selects watchdog checks.
module tb_control_filtro_promedio;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] cfg_ptos_x_ciclo;
    logic [15:0] cfg_frames;
    logic [31:0] cfg_n_salidas;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] muestras_in;
    logic [31:0] salidas_out;

    int n_chk  = 0;
    int n_fail = 0;

    filtro_if bus_if ();

    control_filtro_promedio #(
        .BUF_TAM        (4096),
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .cfg_ptos_x_ciclo (cfg_ptos_x_ciclo),
        .cfg_frames       (cfg_frames),
        .cfg_n_salidas    (cfg_n_salidas),
        .bus              (bus_if),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code),
        .muestras_in      (muestras_in),
        .salidas_out      (salidas_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] m, input logic [15:0] n, input logic [31:0] s);
        cfg_ptos_x_ciclo = m;
        cfg_frames       = n;
        cfg_n_salidas    = s;
    endtask

    // Launch with flt_ready already high: start edge, 2 RST_FLT edges, CLEAR edge, RUN.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_err_clr"}, 32'(error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rstn_lo"}, 32'(bus_if.flt_reset_n), 32'd0);
        tick();
        tick();
        tick();
        chk({tag, "_src_ready"}, 32'(bus_if.src_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(16'd0, 16'd0, 32'd0);
        bus_if.src_valid     = 1'b0;
        bus_if.flt_ready     = 1'b0;
        bus_if.flt_lleno     = 1'b0;
        bus_if.flt_out_valid = 1'b0;
        tick();
        tick();

        chk("rst_flt_reset_n", 32'(bus_if.flt_reset_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_src_ready", 32'(bus_if.src_ready), 32'd0);
        chk("rst_muestras", muestras_in, 32'd0);
        chk("rst_frames", 32'(bus_if.flt_frames), 32'd0);
        reset = 1'b0;
        tick();

        // Nominal run: M=4, N=8, 10 outputs, filter ready two cycles late.
        set_cfg(16'd4, 16'd8, 32'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_rstn_lo0", 32'(bus_if.flt_reset_n), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ptos", 32'(bus_if.flt_ptos_x_ciclo), 32'd4);
        chk("t1_frames", 32'(bus_if.flt_frames), 32'd8);
        tick();
        chk("t1_rstn_lo1", 32'(bus_if.flt_reset_n), 32'd0);
        tick();
        chk("t1_rstn_hi", 32'(bus_if.flt_reset_n), 32'd1);
        chk("t1_clear_src_ready", 32'(bus_if.src_ready), 32'd0);
        tick();
        tick();
        chk("t1_wait_ready", 32'(bus_if.src_ready), 32'd0);
        bus_if.flt_ready = 1'b1;
        tick();
        chk("t1_src_ready", 32'(bus_if.src_ready), 32'd1);
        chk("t1_enable", 32'(bus_if.flt_enable), 32'd1);
        bus_if.src_valid = 1'b1;
        tick();
        chk("t1_data_valid", 32'(bus_if.flt_data_valid), 32'd1);
        chk("t1_muestras1", muestras_in, 32'd1);
        bus_if.flt_out_valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("t1_salidas9", salidas_out, 32'd9);
        chk("t1_not_done9", 32'(done), 32'd0);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_salidas10", salidas_out, 32'd10);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_done_src_ready", 32'(bus_if.src_ready), 32'd0);
        bus_if.flt_out_valid = 1'b0;
        bus_if.src_valid     = 1'b0;
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_salidas_hold", salidas_out, 32'd10);

        // Oversized buffer: 128*64 = 8192 > 4096.
        set_cfg(16'd128, 16'd64, 32'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_code", 32'(err_code), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_rstn", 32'(bus_if.flt_reset_n), 32'd1);
        tick();
        chk("t2_rstn_later", 32'(bus_if.flt_reset_n), 32'd1);
        chk("t2_code_held", 32'(err_code), 32'd1);

        // FIFO full at salidas_out=3; launching from ERR clears the error.
        set_cfg(16'd4, 16'd8, 32'd10);
        launch("t3");
        chk("t3_code_clr", 32'(err_code), 32'd0);
        bus_if.flt_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus_if.flt_out_valid = 1'b0;
        chk("t3_salidas3", salidas_out, 32'd3);
        bus_if.flt_lleno = 1'b1;
        tick();
        bus_if.flt_lleno = 1'b0;
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_code", 32'(err_code), 32'd2);
        chk("t3_enable", 32'(bus_if.flt_enable), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);

        // Final output and FIFO full together: completion wins.
        launch("t4");
        bus_if.flt_out_valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus_if.flt_lleno = 1'b1;
        tick();
        bus_if.flt_lleno     = 1'b0;
        bus_if.flt_out_valid = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_error", 32'(error), 32'd0);
        chk("t4_salidas", salidas_out, 32'd10);
        tick();

        // Abort after 5 forwarded samples.
        launch("t5");
        bus_if.src_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus_if.src_valid = 1'b0;
        chk("t5_muestras5", muestras_in, 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_src_ready", 32'(bus_if.src_ready), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_muestras_hold", muestras_in, 32'd5);
        tick();
        chk("t5_no_done_later", 32'(done), 32'd0);
        chk("t5_muestras_later", muestras_in, 32'd5);

        // Filter never ready.
        bus_if.flt_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 101; i++) tick();
        chk("t6_busy_99", 32'(busy), 32'd1);
        chk("t6_no_err_99", 32'(error), 32'd0);
        tick();
        chk("t6_error", 32'(error), 32'd1);
        chk("t6_code", 32'(err_code), 32'd3);
        chk("t6_busy_after", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 1000; i++) tick();
        chk("t6_busy_1000", 32'(busy), 32'd1);
        chk("t6_no_error", 32'(error), 32'd0);
        chk("t6_src_ready", 32'(bus_if.src_ready), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
